// File: rtl/minibyte_pkg.sv
// Shared types and constants for the minibyte external bus interface.
package minibyte_pkg;

  // Width of the multiplexed address pins.
  localparam int unsigned PIN_W = 8;

  // Width of the shared wait / timeout cycle counter (covers WAIT_STATES and TIMEOUT ranges).
  localparam int unsigned CNT_W = 8;

  // Per-bit output-enable levels; replicated across the data bus by the user.
  localparam logic OE_ALL  = 1'b1;
  localparam logic OE_NONE = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StWait,
    StData,
    StDone
  } state_e;

endpackage

// File: rtl/minibyte_wait_timer.sv
// Loadable, saturating cycle counter shared by the wait-state and timeout phases.
//   clk_i / rst_i : clock, synchronous active-high reset
//   clear_i       : load zero (has priority over inc_i)
//   inc_i         : count one cycle
//   last_i        : terminal value for the current phase
//   tc_o          : count equals last_i (this cycle is the final one of the phase)
module minibyte_wait_timer #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            inc_i,
  input  logic [CntW-1:0] last_i,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      // Saturate instead of wrapping.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/minibyte_bus_if.sv
// CPU-to-external multiplexed byte bus bridge.
// A CPU request is broken into an optional high-address strobe phase, a low-address phase,
// fixed wait states and a data phase stretched by ready_in (with timeout abort).
// All outputs are registered copies of a decode of the registered FSM state, so every pin
// reflects the state of the previous cycle.
//   clk_in, rst_in                       : clock, synchronous active-high reset
//   req_in, we_in, addr_in, wdata_in     : CPU request (sampled in IDLE / DONE only)
//   ack_out, err_out, rdata_out          : completion pulse, timeout flag, read data
//   pin_addr_out, ale_out                : multiplexed address pins, high-byte strobe
//   pin_data_in/out, pin_oe_out, we_out  : external data bus and write strobe
//   ready_in                             : external device ready
module minibyte_bus_if
  import minibyte_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              ack_out,
  output logic              err_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [PIN_W-1:0]  pin_addr_out,
  output logic              ale_out,
  input  logic [DATA_W-1:0] pin_data_in,
  output logic [DATA_W-1:0] pin_data_out,
  output logic [DATA_W-1:0] pin_oe_out,
  output logic              we_out,
  input  logic              ready_in
);

  // Terminal counts: the counter runs 0..N-1 over an N-cycle phase.
  localparam logic [CNT_W-1:0] WaitLast = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);
  localparam logic [CNT_W-1:0] ToLast   = CNT_W'(TIMEOUT - 1);

  state_e state_q, state_d;

  // Captured request.
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // Data-phase result, presented on rdata_out during DONE.
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              timeout_q, timeout_d;

  // Registered outputs.
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [PIN_W-1:0]  pin_addr_q, pin_addr_d;
  logic              ale_q, ale_d;
  logic [DATA_W-1:0] pin_data_q, pin_data_d;
  logic [DATA_W-1:0] pin_oe_q, pin_oe_d;
  logic              we_out_q, we_out_d;

  logic             tmr_clear, tmr_inc, tmr_tc;
  logic [CNT_W-1:0] tmr_last;

  minibyte_wait_timer #(
    .CntW (CNT_W)
  ) u_timer (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .clear_i (tmr_clear),
    .inc_i   (tmr_inc),
    .last_i  (tmr_last),
    .tc_o    (tmr_tc)
  );

  // Clear on entry to WAIT or DATA; one counter serves both since they never overlap.
  assign tmr_clear = (state_d != state_q) && ((state_d == StWait) || (state_d == StData));
  assign tmr_last  = (state_q == StWait) ? WaitLast : ToLast;

  // Next-state and request capture.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_buf_d  = rd_buf_q;
    timeout_d = timeout_q;
    tmr_inc   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (req_in) begin
          we_d      = we_in;
          addr_d    = 16'(addr_in);
          wdata_d   = wdata_in;
          timeout_d = 1'b0;
          state_d   = (ADDR_W == 16) ? StAddrHi : StAddrLo;
        end else begin
          state_d = StIdle;
        end
      end
      StAddrHi: state_d = StAddrLo;
      StAddrLo: state_d = (WAIT_STATES == 0) ? StData : StWait;
      StWait: begin
        tmr_inc = 1'b1;
        if (tmr_tc) begin
          state_d = StData;
        end
      end
      StData: begin
        if (ready_in) begin
          if (!we_q) begin
            rd_buf_d = pin_data_in;
          end
          state_d = StDone;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_tc) begin
            timeout_d = 1'b1;
            if (!we_q) begin
              rd_buf_d = '1;
            end
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the registered state; results are registered once more.
  always_comb begin
    ack_d      = (state_q == StDone);
    err_d      = (state_q == StDone) && timeout_q;
    ale_d      = (state_q == StAddrHi);
    we_out_d   = (state_q == StData) && we_q;
    pin_oe_d   = we_out_d ? {DATA_W{OE_ALL}} : {DATA_W{OE_NONE}};
    pin_data_d = we_out_d ? wdata_q : '0;
    rdata_d    = rdata_q;
    pin_addr_d = pin_addr_q;

    if ((state_q == StDone) && !we_q) begin
      rdata_d = rd_buf_q;
    end
    if (state_q == StAddrHi) begin
      pin_addr_d = addr_q[15:8];
    end else if (state_q == StAddrLo) begin
      pin_addr_d = addr_q[7:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_buf_q   <= '0;
      timeout_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      pin_addr_q <= '0;
      ale_q      <= 1'b0;
      pin_data_q <= '0;
      pin_oe_q   <= '0;
      we_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_buf_q   <= rd_buf_d;
      timeout_q  <= timeout_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      pin_addr_q <= pin_addr_d;
      ale_q      <= ale_d;
      pin_data_q <= pin_data_d;
      pin_oe_q   <= pin_oe_d;
      we_out_q   <= we_out_d;
    end
  end

  assign ack_out      = ack_q;
  assign err_out      = err_q;
  assign rdata_out    = rdata_q;
  assign pin_addr_out = pin_addr_q;
  assign ale_out      = ale_q;
  assign pin_data_out = pin_data_q;
  assign pin_oe_out   = pin_oe_q;
  assign we_out       = we_out_q;

endmodule

// File: doc/minibyte_bus_if.md
MINIBYTE_BUS_IF -- requirements
Module: minibyte_bus_if

Interface
REQ-001: Parameter ADDR_W, default 16, CPU address width; legal values 8 or 16 only.
REQ-002: Parameter DATA_W, default 8, CPU and pin data width.
REQ-003: Parameter WAIT_STATES, default 1, fixed wait cycles between address and data phase; legal range 0..15.
REQ-004: Parameter TIMEOUT, default 64, maximum DATA cycles with ready_in low before abort; legal range 1..255.
REQ-005: clk_in  input  1  the single clock; all logic is on its rising edge.
REQ-006: rst_in  input  1  reset; synchronous and active-high.
REQ-007: req_in  input  1  CPU transaction request.
REQ-008: we_in  input  1  1 = write, 0 = read; sampled with req_in.
REQ-009: addr_in  input  ADDR_W  CPU address; sampled with req_in.
REQ-010: wdata_in  input  DATA_W  write data; sampled with req_in.
REQ-011: ack_out  output  1  one-cycle transaction-complete pulse.
REQ-012: err_out  output  1  one-cycle timeout flag, coincident with ack_out.
REQ-013: rdata_out  output  DATA_W  read data; valid while ack_out=1 and held until the next ack.
REQ-014: pin_addr_out  output  8  multiplexed address pins.
REQ-015: ale_out  output  1  high-address-byte strobe.
REQ-016: pin_data_in  input  DATA_W  external data bus in.
REQ-017: pin_data_out  output  DATA_W  external data bus out.
REQ-018: pin_oe_out  output  DATA_W  per-bit output enable; all-ones or all-zeros.
REQ-019: we_out  output  1  external write strobe.
REQ-020: ready_in  input  1  external device ready; 1 = complete the data phase.

Function
REQ-021: The FSM SHALL have the states IDLE, ADDR_HI, ADDR_LO, WAIT, DATA and DONE.
REQ-022: In IDLE with req_in=1, the block SHALL capture we_in, addr_in and wdata_in, then go to ADDR_HI (ADDR_W=16) or ADDR_LO (ADDR_W=8).
REQ-023: ADDR_HI SHALL last 1 cycle with pin_addr_out=addr[15:8] and ale_out=1; ale_out SHALL be 0 in every other state.
REQ-024: ADDR_LO SHALL last 1 cycle with pin_addr_out=addr[7:0]; pin_addr_out SHALL hold this value through WAIT, DATA and DONE.
REQ-025: After ADDR_LO the FSM SHALL go to WAIT for exactly WAIT_STATES cycles; with WAIT_STATES=0 it SHALL go directly to DATA.
REQ-026: In DATA for a write, pin_data_out=wdata, pin_oe_out=all-ones and we_out=1; in all other states and for reads, pin_oe_out=0 and we_out=0.
REQ-027: In DATA with ready_in=1, a read SHALL latch pin_data_in into rdata_out, and the FSM SHALL go to DONE.
REQ-028: In DATA with ready_in=0, the FSM SHALL stay in DATA and increment the timeout counter.
REQ-029: When the timeout counter reaches TIMEOUT, the FSM SHALL go to DONE with err_out=1, and rdata_out SHALL be all-ones for a read.
REQ-030: In DONE, ack_out SHALL be 1 for exactly one cycle.
REQ-031: In DONE with req_in=1, the next transaction SHALL be captured with no IDLE bubble (back-to-back); otherwise the FSM SHALL go to IDLE.
REQ-032: Nominal latency (ADDR_W=16, WAIT_STATES=1, ready_in=1) SHALL be: ack_out asserted on the 5th rising edge after the edge that accepts req_in.
REQ-033: req_in, we_in, addr_in and wdata_in SHALL be ignored outside IDLE and DONE; captured values SHALL not change mid-transaction.
REQ-034: The wait and timeout counters SHALL clear on entry to WAIT and DATA respectively, and SHALL never wrap.

Reset
REQ-035: With rst_in=1 at a rising edge, the FSM SHALL go to IDLE, including mid-transaction, and no ack_out SHALL be generated for the aborted transaction.
REQ-036: Reset values SHALL be: ack_out=0, err_out=0, rdata_out=0, pin_addr_out=0, ale_out=0, pin_data_out=0, pin_oe_out=0, we_out=0, all counters 0.

Structure
REQ-037: The package minibyte_pkg SHALL hold the FSM state enum, the pin width constant PIN_W=8 and the OE_ALL / OE_NONE constants.
REQ-038: One sub-module, minibyte_wait_timer, SHALL implement the loadable cycle counter used for the wait and timeout counts, with a terminal-count output.
REQ-039: All outputs SHALL be registered; the pin outputs SHALL be driven from registered FSM state.

Verification
REQ-040: Write test: ADDR_W=16, addr 0x12A5, wdata 0x3C, ready_in=1 -> ale_out=1 with pins 0x12, then pins 0xA5, 1 wait cycle, then one DATA cycle with we_out=1, OE=0xFF, data 0x3C, then ack_out on edge 5.
REQ-041: Read test: ADDR_W=8, addr 0x40, WAIT_STATES=0, pin_data_in=0x99 -> no ale_out pulse, rdata_out=0x99 with ack_out on edge 3.
REQ-042: Stretched read: ready_in held low for 3 DATA cycles, then high -> DATA lasts 4 cycles, err_out=0, correct data returned.
REQ-043: Timeout: TIMEOUT=4, ready_in stuck low -> ack_out=1, err_out=1, rdata_out=0xFF, and the FSM returns to IDLE.
REQ-044: Back-to-back: req_in held high over 2 writes -> DONE goes directly to ADDR_HI, giving 2 acks 5 cycles apart.
REQ-045: Reset during DATA of a write -> the next edge has OE=0 and we_out=0, and no ack_out follows.
